// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store initiator sitting between the pipeline and a word-wide data
// memory with asynchronous read and synchronous write. Sub-word stores are
// done as read-modify-write of the containing word, and loads return
// sign- or zero-extended data with a single-cycle response pulse.

module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       memWdata_q, memWdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              reqMisaligned;

    // Byte address bits above the word index wrap silently by design.
    logic unusedAddrBits;
    assign unusedAddrBits = &{1'b0, req_addr[31:ADDR_W+2]};

    // Halfword ops need an even address, word ops need a word-aligned one.
    function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            OP_LH, OP_LHU, OP_SH: isMisaligned = lane[0];
            OP_LW, OP_SW:         isMisaligned = |lane;
            default:              isMisaligned = 1'b0;
        endcase
    endfunction

    // Pick the addressed little-endian lane out of the word and extend it.
    function automatic logic [31:0] extendLoad(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
        logic [7:0]  byteVal;
        logic [15:0] halfVal;
        case (lane)
            2'd0:    byteVal = word[7:0];
            2'd1:    byteVal = word[15:8];
            2'd2:    byteVal = word[23:16];
            default: byteVal = word[31:24];
        endcase
        halfVal = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   extendLoad = {{24{byteVal[7]}}, byteVal};
            OP_LH:   extendLoad = {{16{halfVal[15]}}, halfVal};
            OP_LW:   extendLoad = word;
            OP_LBU:  extendLoad = {24'd0, byteVal};
            OP_LHU:  extendLoad = {16'd0, halfVal};
            default: extendLoad = 32'd0;
        endcase
    endfunction

    // Replace the target byte or halfword lane of the old word with store data.
    function automatic logic [31:0] mergeStore(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] word, input logic [15:0] wdata);
        mergeStore = word;
        if (op == OP_SB) begin
            case (lane)
                2'd0:    mergeStore[7:0]   = wdata[7:0];
                2'd1:    mergeStore[15:8]  = wdata[7:0];
                2'd2:    mergeStore[23:16] = wdata[7:0];
                default: mergeStore[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            mergeStore[31:16] = wdata;
        end else begin
            mergeStore[15:0] = wdata;
        end
    endfunction

    assign reqMisaligned = isMisaligned(req_op, req_addr[1:0]);

    // Next-state logic: accept in IDLE, access memory, then pulse the response.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        memWdata_d = memWdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    if (reqMisaligned) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        addr_d = req_addr[ADDR_W+1:2];
                        if (req_op == OP_SW) begin
                            memWdata_d = req_wdata;
                            state_d    = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (op_q == OP_SB || op_q == OP_SH) begin
                    memWdata_d = mergeStore(op_q, lane_q, mem_rdata, wdata_q);
                    state_d    = WRITE;
                end else begin
                    rdata_d = extendLoad(op_q, lane_q, mem_rdata);
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            WRITE: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; a synchronous reset abandons any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 16'd0;
            addr_q     <= '0;
            memWdata_q <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            memWdata_q <= memWdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign mem_read   = (state_q == READ);
    assign mem_write  = (state_q == WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = memWdata_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Drives directed and random load/store traffic into mem_access_unit backed by
// a simple word memory, and compares results with a byte-level reference model.

module tb_mem_access_unit;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              reqValid = 1'b0;
    logic              reqReady;
    logic [2:0]        reqOp = 3'd0;
    logic [31:0]       reqAddr = 32'd0;
    logic [31:0]       reqWdata = 32'd0;
    logic              respValid;
    logic [31:0]       respRdata;
    logic              respErr;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic              memWrite;
    logic              memRead;
    logic [31:0]       memRdata;

    logic [31:0] mem    [0:(1<<ADDR_W)-1];
    logic [31:0] refMem [0:(1<<ADDR_W)-1];

    int vectors = 0;
    int miscompares = 0;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_op(reqOp),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValid), .resp_rdata(respRdata), .resp_err(respErr),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_write(memWrite),
        .mem_read(memRead), .mem_rdata(memRdata)
    );

    always #5 clk = ~clk;

    // Data memory: asynchronous read, write committed at the clock edge.
    assign memRdata = mem[memAddr];
    always @(posedge clk) begin
        if (memWrite) mem[memAddr] <= memWdata;
    end

    // Reference model, written in terms of byte addresses and lane arithmetic.
    function automatic int unsigned refIndex(input logic [31:0] addr);
        return (addr >> 2) % (1 << ADDR_W);
    endfunction

    function automatic logic refMis(input logic [2:0] op, input logic [31:0] addr);
        if (op == 3'd1 || op == 3'd4 || op == 3'd6) return (addr % 2) != 0;
        if (op == 3'd2 || op == 3'd7) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] w, b, h;
        w = refMem[refIndex(addr)];
        b = (w >> (8 * (addr % 4))) & 32'hFF;
        h = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd2: return w;
            3'd3: return b;
            3'd4: return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic refStore(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned idx, sh;
        logic [31:0] mask;
        idx = refIndex(addr);
        if (op == 3'd7) begin
            refMem[idx] = wdata;
        end else if (op == 3'd5) begin
            sh = 8 * (addr % 4);
            mask = 32'hFF << sh;
            refMem[idx] = (refMem[idx] & ~mask) | ((wdata & 32'hFF) << sh);
        end else if (op == 3'd6) begin
            sh = 16 * ((addr / 2) % 2);
            mask = 32'hFFFF << sh;
            refMem[idx] = (refMem[idx] & ~mask) | ((wdata & 32'hFFFF) << sh);
        end
    endtask

    function automatic int refLatency(input logic [2:0] op, input logic [31:0] addr);
        if (refMis(op, addr)) return 1;
        if (op == 3'd5 || op == 3'd6) return 3;
        return 2;
    endfunction

    // Issue one request and observe it cycle by cycle until its response (bounded).
    task automatic doTxn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nRead, output int nWrite, output int nBoth,
                         output int wrCycle, output logic [ADDR_W-1:0] wrAddr,
                         output logic [31:0] wrData);
        nRead = 0; nWrite = 0; nBoth = 0; wrCycle = 0; wrAddr = '0; wrData = 32'd0;
        rdata = 32'd0; err = 1'b0;
        @(negedge clk);
        reqValid = 1'b1; reqOp = op; reqAddr = addr; reqWdata = wdata;
        @(posedge clk);
        #1 reqValid = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (memRead) nRead++;
            if (memWrite) begin
                nWrite++; wrCycle = lat; wrAddr = memAddr; wrData = memWdata;
            end
            if (memRead && memWrite) nBoth++;
            if (respValid) begin
                rdata = respRdata; err = respErr;
                break;
            end
            if (lat >= 10) begin
                lat = 99;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (reqReady !== 1'b1 || respValid !== 1'b0 || respErr !== 1'b0 || respRdata !== 32'd0 ||
            memRead !== 1'b0 || memWrite !== 1'b0 || memAddr !== '0 || memWdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset: ready=%b rv=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h, required ready=1 and all others 0",
                     reqReady, respValid, respErr, respRdata, memRead, memWrite, memAddr, memWdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_sw_lw();
        logic [31:0] rd, wd; logic er; int lat, nr, nw, nb, wc; logic [ADDR_W-1:0] wa;
        doTxn(3'd7, 32'h10, 32'hDEADBEEF, rd, er, lat, nr, nw, nb, wc, wa, wd);
        refStore(3'd7, 32'h10, 32'hDEADBEEF);
        vectors++;
        if (wc !== 1 || wa !== 10'd4 || wd !== 32'hDEADBEEF || nw !== 1 || nr !== 0) begin
            miscompares++;
            $display("[TB] FAIL sw_write: cycle=%0d addr=%0d data=%h nw=%0d nr=%0d, required 1 4 deadbeef 1 0",
                     wc, wa, wd, nw, nr);
        end
        vectors++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL sw_resp: lat=%0d err=%b rdata=%h, required 2 0 0", lat, er, rd);
        end
        doTxn(3'd2, 32'h10, 32'd0, rd, er, lat, nr, nw, nb, wc, wa, wd);
        vectors++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || nr !== 1 || nw !== 0) begin
            miscompares++;
            $display("[TB] FAIL lw_readback: lat=%0d rdata=%h err=%b nr=%0d nw=%0d, required 2 deadbeef 0 1 0",
                     lat, rd, er, nr, nw);
        end
    endtask

    task automatic test_sb_rmw();
        logic [31:0] rd, wd; logic er; int lat, nr, nw, nb, wc; logic [ADDR_W-1:0] wa;
        doTxn(3'd7, 32'h10, 32'h11223344, rd, er, lat, nr, nw, nb, wc, wa, wd);
        refStore(3'd7, 32'h10, 32'h11223344);
        doTxn(3'd5, 32'h12, 32'h000000AB, rd, er, lat, nr, nw, nb, wc, wa, wd);
        refStore(3'd5, 32'h12, 32'h000000AB);
        vectors++;
        if (nr !== 1 || nw !== 1 || wc !== 2 || wa !== 10'd4 || wd !== 32'h11AB3344) begin
            miscompares++;
            $display("[TB] FAIL sb_rmw: nr=%0d nw=%0d wcycle=%0d addr=%0d data=%h, required 1 1 2 4 11ab3344",
                     nr, nw, wc, wa, wd);
        end
        vectors++;
        if (lat !== 3 || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sb_latency: lat=%0d err=%b, required 3 0", lat, er);
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] rd, wd; logic er; int lat, nr, nw, nb, wc; logic [ADDR_W-1:0] wa;
        logic [2:0]  ops   [4] = '{3'd0, 3'd3, 3'd1, 3'd4};
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        doTxn(3'd7, 32'h10, 32'h80FF7F01, rd, er, lat, nr, nw, nb, wc, wa, wd);
        refStore(3'd7, 32'h10, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) begin
            doTxn(ops[i], addrs[i], 32'd0, rd, er, lat, nr, nw, nb, wc, wa, wd);
            vectors++;
            if (rd !== exps[i] || er !== 1'b0 || lat !== 2) begin
                miscompares++;
                $display("[TB] FAIL load_extend op=%0d addr=%h: rdata=%h err=%b lat=%0d, required %h 0 2",
                         ops[i], addrs[i], rd, er, lat, exps[i]);
            end
        end
        @(negedge clk);
        vectors++;
        if (respValid !== 1'b0 || respRdata !== 32'h00007F01 || reqReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL resp_hold: rv=%b rdata=%h ready=%b, required 0 00007f01 1",
                     respValid, respRdata, reqReady);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, wd; logic er; int lat, nr, nw, nb, wc; logic [ADDR_W-1:0] wa;
        logic [2:0]  ops   [2] = '{3'd2, 3'd6};
        logic [31:0] addrs [2] = '{32'h12, 32'h11};
        for (int i = 0; i < 2; i++) begin
            doTxn(ops[i], addrs[i], 32'hCAFEF00D, rd, er, lat, nr, nw, nb, wc, wa, wd);
            vectors++;
            if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || nr !== 0 || nw !== 0) begin
                miscompares++;
                $display("[TB] FAIL misaligned op=%0d addr=%h: err=%b rdata=%h lat=%0d nr=%0d nw=%0d, required 1 0 1 0 0",
                         ops[i], addrs[i], er, rd, lat, nr, nw);
            end
        end
        doTxn(3'd2, 32'h10, 32'd0, rd, er, lat, nr, nw, nb, wc, wa, wd);
        vectors++;
        if (rd !== refLoad(3'd2, 32'h10) || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL misaligned_followup: rdata=%h err=%b, required %h 0", rd, er, refLoad(3'd2, 32'h10));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, wd; logic er; int lat, nr, nw, nb, wc; logic [ADDR_W-1:0] wa;
        int badEvents;
        @(negedge clk);
        reqValid = 1'b1; reqOp = 3'd5; reqAddr = 32'h12; reqWdata = 32'h55;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        vectors++;
        if (memRead !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_read: mem_read=%b, required 1", memRead);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (reqReady !== 1'b1 || respValid !== 1'b0 || memRead !== 1'b0 || memWrite !== 1'b0 ||
            memAddr !== '0 || memWdata !== 32'd0 || respRdata !== 32'd0 || respErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_state: ready=%b rv=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h err=%b, required 1 and zeros",
                     reqReady, respValid, memRead, memWrite, memAddr, memWdata, respRdata, respErr);
        end
        badEvents = 0;
        repeat (4) begin
            @(negedge clk);
            if (memWrite || respValid || memRead) badEvents++;
        end
        vectors++;
        if (badEvents !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_quiet: %0d strobe/response cycles, required 0", badEvents);
        end
        doTxn(3'd2, 32'h10, 32'd0, rd, er, lat, nr, nw, nb, wc, wa, wd);
        vectors++;
        if (rd !== refLoad(3'd2, 32'h10)) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_mem: word=%h, required %h", rd, refLoad(3'd2, 32'h10));
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, addr, wdata, expRd; logic er; int lat, nr, nw, nb, wc;
        logic [ADDR_W-1:0] wa; logic [2:0] op; logic mis;
        int expR, expW;
        for (int i = 0; i < 8; i++) begin
            wdata = $urandom;
            addr = (32'(i) * 4) | ($urandom & 32'hFFFFF000);
            doTxn(3'd7, addr, wdata, rd, er, lat, nr, nw, nb, wc, wa, wd);
            refStore(3'd7, addr, wdata);
        end
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            addr = $urandom & 32'hFFFFF01F;
            wdata = $urandom;
            mis = refMis(op, addr);
            expRd = (op <= 3'd4 && !mis) ? refLoad(op, addr) : 32'd0;
            expR = (!mis && op != 3'd7) ? 1 : 0;
            expW = (!mis && op >= 3'd5) ? 1 : 0;
            doTxn(op, addr, wdata, rd, er, lat, nr, nw, nb, wc, wa, wd);
            if (!mis) refStore(op, addr, wdata);
            vectors++;
            if (rd !== expRd || er !== mis || lat !== refLatency(op, addr) ||
                nr !== expR || nw !== expW || nb !== 0) begin
                miscompares++;
                $display("[TB] FAIL random op=%0d addr=%h: rdata=%h err=%b lat=%0d nr=%0d nw=%0d both=%0d, required %h %b %0d %0d %0d 0",
                         op, addr, rd, er, lat, nr, nw, nb, expRd, mis, refLatency(op, addr), expR, expW);
            end
            if (expW == 1) begin
                vectors++;
                if (wa !== refIndex(addr) || wd !== refMem[refIndex(addr)]) begin
                    miscompares++;
                    $display("[TB] FAIL random_write op=%0d addr=%h: mem_addr=%0d data=%h, required %0d %h",
                             op, addr, wa, wd, refIndex(addr), refMem[refIndex(addr)]);
                end
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) refMem[i] = 32'd0;
        test_reset();
        test_sw_lw();
        test_sb_rmw();
        test_load_extend();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
